// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-unit result FIFOs feeding a registered round-robin broadcast.
// One cycle from accept to broadcast; each unit is throttled only by its own FIFO occupancy.

module cdb_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             ready,
  output logic [3:0]       count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;
  logic             push_ok;
  logic             pop_ok;

  assign ready   = (count < DEPTH_C);
  assign push_ok = push && ready;
  assign pop_ok  = pop && (count != 4'd0);
  assign head    = mem[rptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= 4'd0;
    end else if (clear) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= 4'd0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (push_ok && !clear) mem[wptr] <= wdata;
  end
endmodule

module cdb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              u0_valid,
  output logic              u0_ready,
  input  logic [1:0]        u0_dest,
  input  logic [1:0]        u0_rs_pos,
  input  logic [DATA_W-1:0] u0_data,
  input  logic              u1_valid,
  output logic              u1_ready,
  input  logic [1:0]        u1_dest,
  input  logic [1:0]        u1_rs_pos,
  input  logic [DATA_W-1:0] u1_data,
  output logic [15:0]       cdb,
  output logic              cdb_valid,
  output logic [3:0]        u0_count,
  output logic [3:0]        u1_count
);
  localparam int EW = DATA_W + 4;

  logic [EW-1:0] head0;
  logic [EW-1:0] head1;
  logic [EW-1:0] sel;
  logic          last_grant;
  logic          any;
  logic          grant_unit;
  logic          pop0;
  logic          pop1;
  logic [2:0]    wr_onehot;
  logic [15:0]   word;

  cdb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u0_fifo (
    .clock(clock), .reset(reset), .clear(flush),
    .push(u0_valid), .pop(pop0),
    .wdata({u0_dest, u0_rs_pos, u0_data}),
    .head(head0), .ready(u0_ready), .count(u0_count)
  );

  cdb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u1_fifo (
    .clock(clock), .reset(reset), .clear(flush),
    .push(u1_valid), .pop(pop1),
    .wdata({u1_dest, u1_rs_pos, u1_data}),
    .head(head1), .ready(u1_ready), .count(u1_count)
  );

  // Unit 1 wins when it is alone, or when both wait and unit 0 went last.
  always_comb begin
    any        = (u0_count != 4'd0) || (u1_count != 4'd0);
    grant_unit = (u1_count != 4'd0) && ((u0_count == 4'd0) || !last_grant);
    pop0       = any && !grant_unit;
    pop1       = any && grant_unit;
    sel        = grant_unit ? head1 : head0;
  end

  always_comb begin
    case (sel[EW-1:EW-2])
      2'd0:    wr_onehot = 3'b100;
      2'd1:    wr_onehot = 3'b010;
      2'd2:    wr_onehot = 3'b001;
      default: wr_onehot = 3'b000;
    endcase
    word = {wr_onehot, sel[EW-3:EW-4], grant_unit, sel[DATA_W-1:0]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cdb        <= 16'h0000;
      cdb_valid  <= 1'b0;
      last_grant <= 1'b1;
    end else if (flush) begin
      cdb       <= 16'h0000;
      cdb_valid <= 1'b0;
    end else if (any) begin
      cdb        <= word;
      cdb_valid  <= 1'b1;
      last_grant <= grant_unit;
    end else begin
      cdb       <= 16'h0000;
      cdb_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a queue-based reference model checked every cycle.
module tb_cdb_arbiter;
  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        u0_valid = 1'b0, u1_valid = 1'b0;
  logic        u0_ready, u1_ready;
  logic [1:0]  u0_dest = 2'd0, u0_rs_pos = 2'd0, u1_dest = 2'd0, u1_rs_pos = 2'd0;
  logic [9:0]  u0_data = 10'd0, u1_data = 10'd0;
  logic [15:0] cdb;
  logic        cdb_valid;
  logic [3:0]  u0_count, u1_count;

  int tests = 0;
  int fails = 0;

  cdb_arbiter #(.DEPTH(DEPTH), .DATA_W(10)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .u0_valid(u0_valid), .u0_ready(u0_ready), .u0_dest(u0_dest),
    .u0_rs_pos(u0_rs_pos), .u0_data(u0_data),
    .u1_valid(u1_valid), .u1_ready(u1_ready), .u1_dest(u1_dest),
    .u1_rs_pos(u1_rs_pos), .u1_data(u1_data),
    .cdb(cdb), .cdb_valid(cdb_valid), .u0_count(u0_count), .u1_count(u1_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: two queues of {dest, rs_pos, data} plus who went last.
  logic [13:0] q0[$];
  logic [13:0] q1[$];
  logic        m_last = 1'b1;
  logic [15:0] m_cdb = 16'h0000;
  logic        m_valid = 1'b0;

  function automatic logic [15:0] fmt(input logic [13:0] e, input logic unit);
    logic [2:0] w;
    w = (e[13:12] == 2'd3) ? 3'b000 : 3'(3'b100 >> e[13:12]);
    return {w, e[11:10], unit, e[9:0]};
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      q0.delete(); q1.delete();
      m_last = 1'b1; m_cdb = 16'h0000; m_valid = 1'b0;
    end else if (flush) begin
      q0.delete(); q1.delete();
      m_cdb = 16'h0000; m_valid = 1'b0;
    end else begin
      bit r0, r1, n0, n1, g;
      logic [13:0] e;
      r0 = q0.size() < DEPTH;
      r1 = q1.size() < DEPTH;
      n0 = q0.size() > 0;
      n1 = q1.size() > 0;
      g  = (n0 && n1) ? !m_last : n1;
      if (n0 || n1) begin
        e = g ? q1.pop_front() : q0.pop_front();
        m_cdb = fmt(e, g); m_valid = 1'b1; m_last = g;
      end else begin
        m_cdb = 16'h0000; m_valid = 1'b0;
      end
      if (u0_valid && r0) q0.push_back({u0_dest, u0_rs_pos, u0_data});
      if (u1_valid && r1) q1.push_back({u1_dest, u1_rs_pos, u1_data});
    end
  end

  logic [9:0] seen1[$];
  bit         saw_full = 0;

  always @(negedge clock) begin
    check("cdb", cdb, m_cdb);
    check("cdb_valid", cdb_valid, m_valid);
    check("u0_count", u0_count, q0.size());
    check("u1_count", u1_count, q1.size());
    check("u0_ready", u0_ready, q0.size() < DEPTH);
    check("u1_ready", u1_ready, q1.size() < DEPTH);
    if (cdb_valid && cdb[10]) seen1.push_back(cdb[9:0]);
    if (u1_count == 4'd2 && !u1_ready) saw_full = 1;
  end

  task automatic set0(input logic v, input logic [1:0] d, input logic [1:0] r, input logic [9:0] x);
    u0_valid = v; u0_dest = d; u0_rs_pos = r; u0_data = x;
  endtask

  task automatic set1(input logic v, input logic [1:0] d, input logic [1:0] r, input logic [9:0] x);
    u1_valid = v; u1_dest = d; u1_rs_pos = r; u1_data = x;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic units[7];
    int   t;

    // Reset held with a pending result: nothing may get through.
    set0(1, 2'd1, 2'd1, 10'd7);
    repeat (2) @(negedge clock);
    check("rst_cdb", cdb, 16'h0000);
    check("rst_valid", cdb_valid, 0);
    check("rst_u0_count", u0_count, 0);
    check("rst_u1_count", u1_count, 0);
    reset = 1'b1;
    set0(0, 2'd0, 2'd0, 10'd0);
    check("rst_u0_ready", u0_ready, 1);
    check("rst_u1_ready", u1_ready, 1);

    // Contention straight out of reset: unit 0 wins the first tie.
    @(negedge clock);
    set0(1, 2'd0, 2'd2, 10'd11);
    set1(1, 2'd2, 2'd0, 10'd4);
    @(negedge clock);
    set0(0, 2'd0, 2'd0, 10'd0);
    set1(0, 2'd0, 2'd0, 10'd0);
    @(negedge clock);
    check("cont_first", cdb, 16'h900B);
    @(negedge clock);
    check("cont_second", cdb, 16'h2404);
    @(negedge clock);
    check("cont_idle", cdb_valid, 0);

    // Single result: one-cycle broadcast then idle zero.
    set0(1, 2'd1, 2'd1, 10'd7);
    @(negedge clock);
    set0(0, 2'd0, 2'd0, 10'd0);
    @(negedge clock);
    check("single_cdb", cdb, 16'h4807);
    check("single_valid", cdb_valid, 1);
    @(negedge clock);
    check("single_after_cdb", cdb, 16'h0000);
    check("single_after_valid", cdb_valid, 0);

    // Sustained dual traffic alternates grants.
    set0(1, 2'd0, 2'd0, 10'd1);
    set1(1, 2'd1, 2'd1, 10'd2);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      units[k] = cdb[10];
    end
    for (int k = 3; k <= 6; k++) check("alternate", units[k] != units[k-1], 1);
    set0(0, 2'd0, 2'd0, 10'd0);
    set1(0, 2'd0, 2'd0, 10'd0);
    repeat (6) @(negedge clock);

    // Backpressure on unit 1 while unit 0 streams.
    seen1.delete();
    saw_full = 0;
    set0(1, 2'd3, 2'd0, 10'h3AA);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      set1(1, 2'(i), 2'(i), 10'(257 + i));
      t = 0;
      while (!u1_ready && t < 20) begin
        @(negedge clock);
        t++;
      end
      check("bp_wait_bound", t < 20, 1);
      @(negedge clock);
    end
    set1(0, 2'd0, 2'd0, 10'd0);
    set0(0, 2'd0, 2'd0, 10'd0);
    repeat (8) @(negedge clock);
    check("bp_saw_full", saw_full, 1);
    check("bp_seen_count", seen1.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < seen1.size()) check("bp_order", seen1[i], 10'(257 + i));

    // No-destination result still broadcasts, with no write bits.
    set0(1, 2'd3, 2'd3, 10'd5);
    @(negedge clock);
    set0(0, 2'd0, 2'd0, 10'd0);
    @(negedge clock);
    check("nodest_cdb", cdb, 16'h1805);
    check("nodest_valid", cdb_valid, 1);
    check("nodest_wr_bits", cdb[15:13], 3'b000);
    repeat (2) @(negedge clock);

    // Flush with buffered results and live pushes.
    set0(1, 2'd0, 2'd1, 10'd20);
    set1(1, 2'd1, 2'd2, 10'd30);
    repeat (5) @(negedge clock);
    check("pre_flush_occupancy", u0_count + u1_count, 3);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush_u0_count", u0_count, 0);
    check("flush_u1_count", u1_count, 0);
    check("flush_valid", cdb_valid, 0);
    check("flush_cdb", cdb, 16'h0000);
    set0(0, 2'd0, 2'd0, 10'd0);
    set1(0, 2'd0, 2'd0, 10'd0);
    repeat (2) @(negedge clock);

    // Asynchronous reset in the middle of a broadcast.
    set0(1, 2'd2, 2'd1, 10'd40);
    set1(1, 2'd0, 2'd3, 10'd50);
    repeat (3) @(negedge clock);
    check("pre_arst_valid", cdb_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_cdb", cdb, 16'h0000);
    check("arst_valid", cdb_valid, 0);
    check("arst_u0_count", u0_count, 0);
    check("arst_u1_count", u1_count, 0);
    #1 reset = 1'b1;
    set0(0, 2'd0, 2'd0, 10'd0);
    set1(0, 2'd0, 2'd0, 10'd0);
    repeat (3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
